// File: rtl/mem_line_fetcher.sv
// rtl/mem_line_fetcher.sv - line-read / word-write backend on a req/gnt/rvalid word bus
module mem_line_fetcher #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int CACHE_LINE_WIDTH = 256
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_mem_read_req,
    input  logic [ADDR_WIDTH-1:0]       i_mem_read_address,
    output logic                        o_mem_read_done,
    output logic [CACHE_LINE_WIDTH-1:0] o_cache_line,
    input  logic                        i_mem_write_valid,
    input  logic [ADDR_WIDTH-1:0]       i_mem_write_address,
    input  logic [DATA_WIDTH-1:0]       i_mem_write_data,
    input  logic [7:0]                  i_write_strobe,
    output logic                        o_mem_write_done,
    output logic                        o_bus_req,
    output logic                        o_bus_we,
    output logic [ADDR_WIDTH-1:0]       o_bus_addr,
    output logic [DATA_WIDTH-1:0]       o_bus_wdata,
    output logic [3:0]                  o_bus_be,
    input  logic                        i_bus_gnt,
    input  logic                        i_bus_rvalid,
    input  logic [DATA_WIDTH-1:0]       i_bus_rdata
);

    localparam int WORDS = CACHE_LINE_WIDTH / DATA_WIDTH;
    localparam int KW    = $clog2(WORDS);
    localparam int OFF   = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int WB    = $clog2(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_DONE,
        RD_HOLD,
        WR_ISSUE,
        WR_DONE,
        WR_HOLD
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [KW-1:0]         k_q;

    logic [KW-1:0]         k_inc;
    logic [ADDR_WIDTH-1:0] next_word_addr;
    logic [ADDR_WIDTH-1:0] rd_base;
    logic [ADDR_WIDTH-1:0] wr_word_addr;
    logic [3:0]            wr_be;
    logic                  wr_has_be;
    logic                  unused_bits;

    assign k_inc          = k_q + KW'(1);
    // Word offsets wrap naturally at the top of the address space.
    assign next_word_addr = base_q + ADDR_WIDTH'({k_inc, {WB{1'b0}}});
    assign rd_base        = {i_mem_read_address[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    assign wr_word_addr   = {i_mem_write_address[ADDR_WIDTH-1:WB], {WB{1'b0}}};
    assign wr_be          = i_write_strobe[3:0];
    assign wr_has_be      = |wr_be;
    assign unused_bits    = ^{i_write_strobe[7:4], i_mem_read_address[OFF-1:0],
                              i_mem_write_address[WB-1:0]};

    // Single FSM: state, word counter, line assembly and all registered outputs.
    // Bus payload is loaded on entry to an issue state and cleared on grant, so it
    // stays stable while waiting for gnt and is zero everywhere else.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q          <= IDLE;
            base_q           <= '0;
            k_q              <= '0;
            o_cache_line     <= '0;
            o_mem_read_done  <= 1'b0;
            o_mem_write_done <= 1'b0;
            o_bus_req        <= 1'b0;
            o_bus_we         <= 1'b0;
            o_bus_addr       <= '0;
            o_bus_wdata      <= '0;
            o_bus_be         <= 4'h0;
        end else begin
            o_mem_read_done  <= 1'b0;
            o_mem_write_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_mem_write_valid) begin
                        // An all-zero strobe keeps the bus idle; WR_ISSUE then finishes at once.
                        state_q     <= WR_ISSUE;
                        o_bus_req   <= wr_has_be;
                        o_bus_we    <= wr_has_be;
                        o_bus_addr  <= wr_has_be ? wr_word_addr : '0;
                        o_bus_wdata <= wr_has_be ? i_mem_write_data : '0;
                        o_bus_be    <= wr_be;
                    end else if (i_mem_read_req) begin
                        state_q    <= RD_ISSUE;
                        base_q     <= rd_base;
                        k_q        <= '0;
                        o_bus_req  <= 1'b1;
                        o_bus_we   <= 1'b0;
                        o_bus_addr <= rd_base;
                        o_bus_be   <= 4'hF;
                    end
                end
                RD_ISSUE: begin
                    if (i_bus_gnt) begin
                        state_q    <= RD_WAIT;
                        o_bus_req  <= 1'b0;
                        o_bus_addr <= '0;
                        o_bus_be   <= 4'h0;
                    end
                end
                RD_WAIT: begin
                    if (i_bus_rvalid) begin
                        o_cache_line[int'(k_q)*DATA_WIDTH +: DATA_WIDTH] <= i_bus_rdata;
                        if (k_q == KW'(WORDS - 1)) begin
                            state_q         <= RD_DONE;
                            o_mem_read_done <= 1'b1;
                        end else begin
                            state_q    <= RD_ISSUE;
                            k_q        <= k_inc;
                            o_bus_req  <= 1'b1;
                            o_bus_addr <= next_word_addr;
                            o_bus_be   <= 4'hF;
                        end
                    end
                end
                RD_DONE: begin
                    state_q <= RD_HOLD;
                end
                RD_HOLD: begin
                    // Upstream drops its level request late; wait so we never refetch.
                    if (!i_mem_read_req) begin
                        state_q <= IDLE;
                    end
                end
                WR_ISSUE: begin
                    if (i_bus_gnt || (o_bus_be == 4'h0)) begin
                        state_q          <= WR_DONE;
                        o_mem_write_done <= 1'b1;
                        o_bus_req        <= 1'b0;
                        o_bus_we         <= 1'b0;
                        o_bus_addr       <= '0;
                        o_bus_wdata      <= '0;
                        o_bus_be         <= 4'h0;
                    end
                end
                WR_DONE: begin
                    state_q <= WR_HOLD;
                end
                WR_HOLD: begin
                    if (!i_mem_write_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_fetcher.sv
// tb/tb_mem_line_fetcher.sv - directed bench for mem_line_fetcher
module tb_mem_line_fetcher;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         read_req;
    logic [31:0]  read_addr;
    logic         rd_done;
    logic [255:0] cache_line;
    logic         write_valid;
    logic [31:0]  write_addr;
    logic [31:0]  write_data;
    logic [7:0]   write_strobe;
    logic         wr_done;
    logic         bus_req;
    logic         bus_we;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [3:0]   bus_be;
    logic         bus_gnt;
    logic         bus_rvalid;
    logic [31:0]  bus_rdata;

    always #5 clk = ~clk;

    mem_line_fetcher dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_mem_read_req      (read_req),
        .i_mem_read_address  (read_addr),
        .o_mem_read_done     (rd_done),
        .o_cache_line        (cache_line),
        .i_mem_write_valid   (write_valid),
        .i_mem_write_address (write_addr),
        .i_mem_write_data    (write_data),
        .i_write_strobe      (write_strobe),
        .o_mem_write_done    (wr_done),
        .o_bus_req           (bus_req),
        .o_bus_we            (bus_we),
        .o_bus_addr          (bus_addr),
        .o_bus_wdata         (bus_wdata),
        .o_bus_be            (bus_be),
        .i_bus_gnt           (bus_gnt),
        .i_bus_rvalid        (bus_rvalid),
        .i_bus_rdata         (bus_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          gnt_delay = 0;
    int          rv_delay  = 1;
    logic [31:0] rdata_base = 32'h0;
    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [3:0]  log_be[$];
    logic [31:0] log_wdata[$];
    int          rd_done_cnt = 0;
    int          wr_done_cnt = 0;
    int          rd_done_cyc = 0;
    int          wr_done_cyc = 0;

    // Bus slave model plus done monitor; runs 1 time unit after each rising edge.
    initial begin
        int          wait_cnt;
        int          rv_cnt;
        logic        outstanding;
        logic        gnt_we;
        logic [31:0] gnt_addr;
        logic [31:0] pend_addr;
        logic [31:0] cap_addr;
        logic [31:0] cap_wdata;
        logic [3:0]  cap_be;
        logic        cap_we;
        wait_cnt = 0; rv_cnt = 0; outstanding = 1'b0; gnt_we = 1'b0;
        gnt_addr = '0; pend_addr = '0;
        cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_done) begin rd_done_cnt++; rd_done_cyc = cyc; end
            if (wr_done) begin wr_done_cnt++; wr_done_cyc = cyc; end
            if (bus_gnt && !gnt_we) begin
                rv_cnt      = rv_delay;
                pend_addr   = gnt_addr;
                outstanding = 1'b1;
            end
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bus_rvalid  = 1'b1;
                    bus_rdata   = rdata_base + ((pend_addr >> 2) & 32'h7);
                    outstanding = 1'b0;
                end
            end
            if (bus_req && rst_n) begin
                check("one_outstanding", outstanding, 1'b0);
                if (wait_cnt == 0) begin
                    cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_we = bus_we;
                end else begin
                    check("stable_addr", bus_addr, cap_addr);
                    check("stable_wdata", bus_wdata, cap_wdata);
                    check("stable_be", bus_be, cap_be);
                    check("stable_we", bus_we, cap_we);
                end
                if (wait_cnt >= gnt_delay) begin
                    bus_gnt  = 1'b1;
                    gnt_we   = bus_we;
                    gnt_addr = bus_addr;
                    log_addr.push_back(bus_addr);
                    log_we.push_back(bus_we);
                    log_be.push_back(bus_be);
                    log_wdata.push_back(bus_wdata);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        log_addr.delete(); log_we.delete(); log_be.delete(); log_wdata.delete();
    endtask

    task automatic wait_rd(input int n0);
        for (int i = 0; i < 400 && rd_done_cnt == n0; i++) tick();
        check("rd_done_seen", rd_done_cnt - n0, 1);
    endtask

    task automatic wait_wr(input int n0);
        for (int i = 0; i < 100 && wr_done_cnt == n0; i++) tick();
        check("wr_done_seen", wr_done_cnt - n0, 1);
    endtask

    task automatic check_line(input logic [31:0] base);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("line_w%0d", k), cache_line[32*k +: 32], base + 32'(k));
        end
    endtask

    task automatic check_read_addrs(input logic [31:0] base);
        check("rd_access_cnt", log_addr.size(), 8);
        for (int k = 0; k < 8 && k < log_addr.size(); k++) begin
            check($sformatf("rd_addr%0d", k), log_addr[k], base + 32'(4 * k));
            check($sformatf("rd_we%0d", k), log_we[k], 1'b0);
            check($sformatf("rd_be%0d", k), log_be[k], 4'hF);
        end
    endtask

    initial begin
        int n;
        int nw;
        int start;
        rst_n = 1'b0; read_req = 1'b0; read_addr = '0;
        write_valid = 1'b0; write_addr = '0; write_data = '0; write_strobe = '0;
        repeat (3) tick();
        check("rst_line", cache_line, '0);
        check("rst_req", bus_req, 1'b0);
        check("rst_we", bus_we, 1'b0);
        check("rst_addr", bus_addr, '0);
        check("rst_wdata", bus_wdata, '0);
        check("rst_be", bus_be, '0);
        check("rst_rd_done", rd_done, 1'b0);
        check("rst_wr_done", wr_done, 1'b0);
        rst_n = 1'b1;
        tick();

        // Zero-wait read of an unaligned address, then re-arm hold.
        gnt_delay = 0; rv_delay = 1; rdata_base = 32'h1000; clear_log();
        n = rd_done_cnt; start = cyc;
        read_addr = 32'h0000_D01C; read_req = 1'b1;
        wait_rd(n);
        check("rd_latency", rd_done_cyc - start, 17);
        check_read_addrs(32'h0000_D000);
        check_line(32'h1000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rearm_no_req", bus_req, 1'b0);
            check("rd_done_single", rd_done, 1'b0);
        end
        check("rd_done_once", rd_done_cnt - n, 1);
        check("rearm_no_access", log_addr.size(), 8);
        read_req = 1'b0;
        tick(); tick();
        rdata_base = 32'h2000; clear_log(); n = rd_done_cnt;
        read_req = 1'b1;
        wait_rd(n);
        check_read_addrs(32'h0000_D000);
        check_line(32'h2000);
        read_req = 1'b0;
        tick(); tick();

        // Slow bus: gnt after 2 wait cycles, rvalid 3 cycles after gnt.
        gnt_delay = 2; rv_delay = 3; rdata_base = 32'h3000; clear_log(); n = rd_done_cnt;
        read_addr = 32'h0000_0040; read_req = 1'b1;
        wait_rd(n);
        check_read_addrs(32'h0000_0040);
        check_line(32'h3000);
        repeat (3) tick();
        check("slow_done_once", rd_done_cnt - n, 1);
        read_req = 1'b0;
        tick(); tick();

        // Byte-enabled write.
        gnt_delay = 0; rv_delay = 1; clear_log(); nw = wr_done_cnt; start = cyc;
        write_addr = 32'h0000_D006; write_data = 32'hDEAD_BEEF; write_strobe = 8'hF3;
        write_valid = 1'b1;
        wait_wr(nw);
        check("wr_latency", wr_done_cyc - start, 2);
        check("wr_access_cnt", log_addr.size(), 1);
        if (log_addr.size() > 0) begin
            check("wr_addr", log_addr[0], 32'h0000_D004);
            check("wr_be", log_be[0], 4'h3);
            check("wr_we", log_we[0], 1'b1);
            check("wr_wdata", log_wdata[0], 32'hDEAD_BEEF);
        end
        tick();
        check("wr_done_single", wr_done, 1'b0);
        write_valid = 1'b0;
        tick(); tick();

        // Empty strobe: no bus access, done still pulses.
        clear_log(); nw = wr_done_cnt; start = cyc;
        write_strobe = 8'hF0; write_valid = 1'b1;
        wait_wr(nw);
        check("wr0_latency", wr_done_cyc - start, 2);
        check("wr0_no_access", log_addr.size(), 0);
        write_valid = 1'b0;
        tick(); tick();

        // Simultaneous requests: write first, read only after write_valid drops.
        clear_log(); nw = wr_done_cnt; n = rd_done_cnt; rdata_base = 32'h4000;
        write_addr = 32'h0000_D008; write_data = 32'h1234_5678; write_strobe = 8'h0F;
        read_addr = 32'h0000_D01C;
        write_valid = 1'b1; read_req = 1'b1;
        wait_wr(nw);
        check("both_first_we", (log_we.size() > 0) ? log_we[0] : 1'b0, 1'b1);
        repeat (3) tick();
        check("both_read_blocked", log_addr.size(), 1);
        check("both_no_rd_done", rd_done_cnt - n, 0);
        write_valid = 1'b0;
        wait_rd(n);
        check("both_access_cnt", log_addr.size(), 9);
        check_line(32'h4000);
        read_req = 1'b0;
        tick(); tick();

        // Reset during word 4 of a fetch, with rvalid landing after reset.
        rv_delay = 2; rdata_base = 32'h5000; clear_log(); n = rd_done_cnt;
        read_addr = 32'h0000_0100; read_req = 1'b1;
        for (int i = 0; i < 100 && log_addr.size() < 5; i++) tick();
        check("rst_mid_reached_w4", log_addr.size(), 5);
        tick();
        rst_n = 1'b0; read_req = 1'b0;
        repeat (3) tick();
        check("rst_mid_line", cache_line, '0);
        check("rst_mid_req", bus_req, 1'b0);
        check("rst_mid_be", bus_be, '0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("rst_mid_no_done", rd_done_cnt - n, 0);
        check("rst_mid_line_after", cache_line, '0);
        rv_delay = 1; rdata_base = 32'h6000; clear_log(); n = rd_done_cnt;
        read_req = 1'b1;
        wait_rd(n);
        check_read_addrs(32'h0000_0100);
        check_line(32'h6000);
        read_req = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
